lsu_mem_initiator: RTL and testbench

Load/store initiator for the MEM stage: accepts one load or store request per handshake from the pipeline and drives the data-memory port (read enable, write enable, funct, address, write data).
- Returns load data sign- or zero-extended per funct, or a store completion, as a one-cycle response pulse.
- Optionally decomposes misaligned halfword/word accesses into sequential byte accesses.
- Sits between the EX/MEM pipeline register and the data RAM.
- Funct codes are the `FUNC_*` macros from `define.v`.

---
 rtl/lsu_mem_initiator_if.sv | 41 ++++
 rtl/lsu_mem_initiator.sv | 137 +++++++++++++
 tb/tb_lsu_mem_initiator.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: request/response and data-memory port bundle for lsu_mem_initiator.
// master: the initiator (drives req_ready, resp_*, mem_* except rdata).
// slave: pipeline plus data RAM (drives req_*, mem_rdata_i).
// Also provides the FUNC_* width codes when define.v is not already in scope.
`ifndef FUNC_LB
`define FUNC_LB  10'd1
`define FUNC_LH  10'd2
`define FUNC_LW  10'd3
`define FUNC_LBU 10'd4
`define FUNC_LHU 10'd5
`define FUNC_SB  10'd6
`define FUNC_SH  10'd7
`define FUNC_SW  10'd8
`endif
interface lsu_mem_initiator_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_load_i;
  logic [9:0]  req_funct_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_r_en_o;
  logic        mem_w_en_o;
  logic [9:0]  mem_funct_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  modport master (
    input  req_valid_i, req_load_i, req_funct_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_r_en_o, mem_w_en_o, mem_funct_o, mem_addr_o, mem_wdata_o
  );
  modport slave (
    output req_valid_i, req_load_i, req_funct_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_r_en_o, mem_w_en_o, mem_funct_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: MEM-stage load/store initiator between the EX/MEM register and the data RAM.
// Ports: clk_i, rst_i (sync, active-high); bus (lsu_mem_initiator_if.master) carrying the
// request handshake, one-cycle response pulse and the data-memory port.
// Optional MISALIGN_SPLIT_EN: misaligned H/W accesses are split into byte accesses;
// without it they complete immediately with resp_err_o.
`ifndef FUNC_LB
`define FUNC_LB  10'd1
`define FUNC_LH  10'd2
`define FUNC_LW  10'd3
`define FUNC_LBU 10'd4
`define FUNC_LHU 10'd5
`define FUNC_SB  10'd6
`define FUNC_SH  10'd7
`define FUNC_SW  10'd8
`endif
module lsu_mem_initiator #(
  parameter int ADDR_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  lsu_mem_initiator_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd3;
  logic [1:0] state_q, state_d;
  logic load_q, load_d, err_q, err_d;
  logic [9:0] funct_q, funct_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [9:0] f;
  logic f_h, f_w, legal, mis, acc, spl, rsp;
  logic [1:0] k;
  assign f     = bus.req_funct_i;
  assign f_h   = f == `FUNC_LH || f == `FUNC_LHU || f == `FUNC_SH;
  assign f_w   = f == `FUNC_LW || f == `FUNC_SW;
  assign legal = bus.req_load_i
               ? (f == `FUNC_LB || f == `FUNC_LH || f == `FUNC_LW || f == `FUNC_LBU || f == `FUNC_LHU)
               : (f == `FUNC_SB || f == `FUNC_SH || f == `FUNC_SW);
  assign mis   = (f_h && bus.req_addr_i[0]) || (f_w && bus.req_addr_i[1:0] != 2'b00);
  assign acc   = state_q == ACCESS;
  assign rsp   = state_q == RESP;
`ifdef MISALIGN_SPLIT_EN
  localparam logic [1:0] SPLIT = 2'd2;
  logic [1:0] k_q, k_d;
  logic h_q;
  assign h_q = funct_q == `FUNC_LH || funct_q == `FUNC_LHU || funct_q == `FUNC_SH;
  assign spl = state_q == SPLIT;
  assign k   = k_q;
`else
  assign spl = 1'b0;
  assign k   = 2'd0;
`endif
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    err_d   = err_q;
    funct_d = funct_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
`ifdef MISALIGN_SPLIT_EN
    k_d     = k_q;
`endif
    if (state_q == IDLE) begin
      if (bus.req_valid_i) begin
        load_d  = bus.req_load_i;
        funct_d = f;
        addr_d  = bus.req_addr_i;
        wdata_d = bus.req_wdata_i;
        buf_d   = '0;
`ifdef MISALIGN_SPLIT_EN
        err_d   = !legal;
        k_d     = 2'd0;
        state_d = !legal ? RESP : mis ? SPLIT : ACCESS;
`else
        err_d   = !legal || mis;
        state_d = (!legal || mis) ? RESP : ACCESS;
`endif
      end
    end else if (acc) begin
      buf_d   = load_q ? bus.mem_rdata_i : buf_q;
      state_d = RESP;
    end
`ifdef MISALIGN_SPLIT_EN
    else if (spl) begin
      if (load_q) buf_d[{k_q, 3'b000} +: 8] = bus.mem_rdata_i[7:0];
      k_d     = k_q + 2'd1;
      state_d = (k_q == (h_q ? 2'd1 : 2'd3)) ? RESP : SPLIT;
    end
`endif
    else begin
      state_d = IDLE;
    end
  end
  always_comb begin
    bus.req_ready_o  = state_q == IDLE;
    bus.mem_r_en_o   = (acc || spl) && load_q;
    bus.mem_w_en_o   = (acc || spl) && !load_q;
    bus.mem_funct_o  = acc ? funct_q : spl ? (load_q ? `FUNC_LBU : `FUNC_SB) : 10'd0;
    bus.mem_addr_o   = acc ? addr_q : spl ? addr_q + ADDR_W'(k) : '0;
    bus.mem_wdata_o  = acc ? wdata_q : spl ? wdata_q >> {k, 3'b000} : 32'd0;
    bus.resp_valid_o = rsp;
    bus.resp_err_o   = rsp && err_q;
    bus.resp_rdata_o = !(rsp && !err_q && load_q) ? 32'd0
                     : funct_q == `FUNC_LB  ? {{24{buf_q[7]}}, buf_q[7:0]}
                     : funct_q == `FUNC_LH  ? {{16{buf_q[15]}}, buf_q[15:0]}
                     : funct_q == `FUNC_LBU ? {24'd0, buf_q[7:0]}
                     : funct_q == `FUNC_LHU ? {16'd0, buf_q[15:0]}
                     : buf_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      funct_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      k_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      err_q   <= err_d;
      funct_q <= funct_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
`ifdef MISALIGN_SPLIT_EN
      k_q     <= k_d;
`endif
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed self-checking bench for lsu_mem_initiator with a byte-array RAM model.
`ifndef FUNC_LB
`define FUNC_LB  10'd1
`define FUNC_LH  10'd2
`define FUNC_LW  10'd3
`define FUNC_LBU 10'd4
`define FUNC_LHU 10'd5
`define FUNC_SB  10'd6
`define FUNC_SH  10'd7
`define FUNC_SW  10'd8
`endif
module tb_lsu_mem_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] mem [256];
  logic [7:0] ma;
  lsu_mem_initiator_if m();
  lsu_mem_initiator dut (.clk_i(clk), .rst_i(rst), .bus(m));
  always #5 clk = ~clk;
  assign ma = m.mem_addr_o[7:0];
  assign m.mem_rdata_i = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
  function automatic int nbytes(input logic [9:0] fn);
    return fn == `FUNC_SB ? 1 : fn == `FUNC_SH ? 2 : 4;
  endfunction
  always @(posedge clk)
    if (m.mem_w_en_o)
      for (int i = 0; i < nbytes(m.mem_funct_o); i++) mem[ma + 8'(i)] = m.mem_wdata_o[8*i +: 8];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic ld, input logic [9:0] fn, input logic [31:0] a, input logic [31:0] w);
    m.req_valid_i = 1'b1;
    m.req_load_i  = ld;
    m.req_funct_i = fn;
    m.req_addr_i  = a;
    m.req_wdata_i = w;
    @(negedge clk);
    m.req_valid_i = 1'b0;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".rdy"}, 32'(m.req_ready_o), 32'd1);
    chk({tag, ".rv"}, {m.resp_valid_o, m.resp_err_o, m.mem_r_en_o, m.mem_w_en_o}, 32'd0);
  endtask
  task automatic aligned_load(input string tag, input logic [9:0] fn, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b1, fn, a, 32'd0);
    chk({tag, ".en"}, {m.req_ready_o, m.mem_r_en_o, m.mem_w_en_o, m.resp_valid_o}, 32'b0100);
    chk({tag, ".fn"}, 32'(m.mem_funct_o), 32'(fn));
    chk({tag, ".addr"}, m.mem_addr_o, a);
    @(negedge clk);
    chk({tag, ".rv"}, {m.resp_valid_o, m.resp_err_o, m.mem_r_en_o}, 32'b100);
    chk({tag, ".rdata"}, m.resp_rdata_o, exp);
    @(negedge clk);
    idle_chk({tag, ".end"});
  endtask
  task automatic aligned_store(input string tag, input logic [9:0] fn, input logic [31:0] a, input logic [31:0] w);
    issue(1'b0, fn, a, w);
    chk({tag, ".en"}, {m.req_ready_o, m.mem_r_en_o, m.mem_w_en_o, m.resp_valid_o}, 32'b0010);
    chk({tag, ".fn"}, 32'(m.mem_funct_o), 32'(fn));
    chk({tag, ".wdata"}, m.mem_wdata_o, w);
    @(negedge clk);
    chk({tag, ".rv"}, {m.resp_valid_o, m.resp_err_o}, 32'b10);
    chk({tag, ".rdata"}, m.resp_rdata_o, 32'd0);
    @(negedge clk);
    idle_chk({tag, ".end"});
  endtask
  task automatic err_case(input string tag, input logic ld, input logic [9:0] fn, input logic [31:0] a);
    issue(ld, fn, a, 32'hFFFFFFFF);
    chk({tag, ".rv"}, {m.resp_valid_o, m.resp_err_o, m.mem_r_en_o, m.mem_w_en_o}, 32'b1100);
    chk({tag, ".rdata"}, m.resp_rdata_o, 32'd0);
    @(negedge clk);
    idle_chk({tag, ".end"});
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'hF0; mem[8'h12] = 8'h01; mem[8'h13] = 8'h80;
    mem[8'h03] = 8'hF0; mem[8'h07] = 8'h34; mem[8'h08] = 8'h92;
    mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22;
    m.req_valid_i = 1'b0; m.req_load_i = 1'b0; m.req_funct_i = '0; m.req_addr_i = '0; m.req_wdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_chk("reset");
    chk("reset.mem", m.mem_addr_o | m.mem_wdata_o | 32'(m.mem_funct_o) | m.resp_rdata_o, 32'd0);
    aligned_load("lw", `FUNC_LW, 32'h80000010, 32'h8001F0A5);
    aligned_load("lb", `FUNC_LB, 32'h80000003, 32'hFFFFFFF0);
    aligned_load("lbu", `FUNC_LBU, 32'h80000003, 32'h000000F0);
    aligned_load("lh", `FUNC_LH, 32'h80000010, 32'hFFFFF0A5);
    aligned_load("lhu", `FUNC_LHU, 32'h80000010, 32'h0000F0A5);
    aligned_store("sw", `FUNC_SW, 32'h80000020, 32'h11223344);
    aligned_load("lw_sw", `FUNC_LW, 32'h80000020, 32'h11223344);
    aligned_store("sb", `FUNC_SB, 32'h80000021, 32'h000000AB);
    aligned_load("lw_sb", `FUNC_LW, 32'h80000020, 32'h1122AB44);
    err_case("st_lw", 1'b0, `FUNC_LW, 32'h80000030);
    err_case("ld_sb", 1'b1, `FUNC_SB, 32'h80000030);
    err_case("ld_bad", 1'b1, 10'h3FF, 32'h80000030);
    issue(1'b1, `FUNC_LW, 32'h80000010, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.out", {m.resp_valid_o, m.mem_r_en_o, m.mem_w_en_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_chk("rst_mid");
`ifdef MISALIGN_SPLIT_EN
    issue(1'b0, `FUNC_SW, 32'h80000001, 32'hDDCCBBAA);
    for (int k = 0; k < 4; k++) begin
      chk("ssw.en", {m.req_ready_o, m.mem_r_en_o, m.mem_w_en_o, m.resp_valid_o}, 32'b0010);
      chk("ssw.fn", 32'(m.mem_funct_o), 32'(`FUNC_SB));
      chk("ssw.addr", m.mem_addr_o, 32'h80000001 + 32'(k));
      chk("ssw.wdata", m.mem_wdata_o, 32'hDDCCBBAA >> (8 * k));
      @(negedge clk);
    end
    chk("ssw.rv", {m.resp_valid_o, m.resp_err_o, m.mem_w_en_o}, 32'b100);
    chk("ssw.rdata", m.resp_rdata_o, 32'd0);
    @(negedge clk);
    idle_chk("ssw.end");
    chk("ssw.mem", {mem[4], mem[3], mem[2], mem[1]}, 32'hDDCCBBAA);
    issue(1'b1, `FUNC_LH, 32'h80000007, 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("slh.en", {m.mem_r_en_o, m.mem_w_en_o, m.resp_valid_o}, 32'b100);
      chk("slh.fn", 32'(m.mem_funct_o), 32'(`FUNC_LBU));
      chk("slh.addr", m.mem_addr_o, 32'h80000007 + 32'(k));
      @(negedge clk);
    end
    chk("slh.rv", {m.resp_valid_o, m.resp_err_o}, 32'b10);
    chk("slh.rdata", m.resp_rdata_o, 32'hFFFF9234);
    @(negedge clk);
    idle_chk("slh.end");
    issue(1'b1, `FUNC_LW, 32'hFFFFFFFF, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("wrap.en", {m.mem_r_en_o, m.resp_valid_o}, 32'b10);
      chk("wrap.addr", m.mem_addr_o, 32'hFFFFFFFF + 32'(k));
      @(negedge clk);
    end
    chk("wrap.rv", {m.resp_valid_o, m.resp_err_o}, 32'b10);
    chk("wrap.rdata", m.resp_rdata_o, 32'hBBAA2211);
    @(negedge clk);
    idle_chk("wrap.end");
    issue(1'b0, `FUNC_SW, 32'h80000041, 32'h55667788);
    chk("srst.k0", {m.mem_w_en_o, m.mem_addr_o[7:0]}, {1'b1, 8'h41});
    @(negedge clk);
    chk("srst.k1", {m.mem_w_en_o, m.mem_addr_o[7:0]}, {1'b1, 8'h42});
    rst = 1'b1;
    @(negedge clk);
    chk("srst.out", {m.resp_valid_o, m.mem_r_en_o, m.mem_w_en_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_chk("srst");
    @(negedge clk);
    chk("srst.norsp", 32'(m.resp_valid_o), 32'd0);
    chk("srst.mem", {mem[8'h43], mem[8'h42], mem[8'h41]}, 32'h00007788);
`else
    err_case("mis_lw", 1'b1, `FUNC_LW, 32'h80000002);
    err_case("mis_sh", 1'b0, `FUNC_SH, 32'h80000011);
    err_case("mis_lh", 1'b1, `FUNC_LH, 32'h80000007);
    chk("mis.mem", {mem[8'h12], mem[8'h11]}, 32'h000001F0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
